// File: rtl/alu_decode_stage.sv
// RV32I decode stage: turns an instruction word into ALU control, operand
// selects and a sign-extended immediate, held in a single-entry pipeline
// register with valid/ready handshaking on both sides.
module alu_decode_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  alu_control,
  output logic        src1_sel,
  output logic        src2_sel,
  output logic [31:0] imm,
  output logic        illegal
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SLT  = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_OR   = 4'b1001;
  localparam logic [3:0] ALU_AND  = 4'b1011;
  localparam logic [3:0] ALU_PASS = 4'b1111;

  // Operation selected by funct3 when funct7 is the base encoding (R and I-ALU).
  function automatic logic [3:0] base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  base_op = ALU_ADD;
      3'b001:  base_op = ALU_SLL;
      3'b010:  base_op = ALU_SLT;
      3'b011:  base_op = ALU_SLTU;
      3'b100:  base_op = ALU_XOR;
      3'b101:  base_op = ALU_SRL;
      3'b110:  base_op = ALU_OR;
      3'b111:  base_op = ALU_AND;
      default: base_op = ALU_ADD;
    endcase
  endfunction

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'h000};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  logic [3:0]  raw_ctrl;
  logic        raw_src1;
  logic        raw_src2;
  logic [31:0] raw_imm;
  logic        dec_ill;

  // Decode the incoming word; illegal encodings are flagged here and zeroed below.
  always_comb begin
    raw_ctrl = ALU_ADD;
    raw_src1 = 1'b0;
    raw_src2 = 1'b0;
    raw_imm  = 32'h0000_0000;
    dec_ill  = 1'b0;
    case (opcode)
      OP_R: begin
        if (funct7 == F7_BASE) begin
          raw_ctrl = base_op(funct3);
        end else if ((funct7 == F7_ALT) && (funct3 == 3'b000)) begin
          raw_ctrl = ALU_SUB;
        end else if ((funct7 == F7_ALT) && (funct3 == 3'b101)) begin
          raw_ctrl = ALU_SRA;
        end else begin
          dec_ill = 1'b1;
        end
      end
      OP_I_ALU: begin
        raw_src2 = 1'b1;
        raw_imm  = imm_i;
        if (funct3 == 3'b001) begin
          raw_ctrl = ALU_SLL;
          dec_ill  = (funct7 != F7_BASE);
        end else if (funct3 == 3'b101) begin
          if (funct7 == F7_BASE) begin
            raw_ctrl = ALU_SRL;
          end else if (funct7 == F7_ALT) begin
            raw_ctrl = ALU_SRA;
          end else begin
            dec_ill = 1'b1;
          end
        end else begin
          raw_ctrl = base_op(funct3);
        end
      end
      OP_LUI: begin
        raw_ctrl = ALU_PASS;
        raw_src2 = 1'b1;
        raw_imm  = imm_u;
      end
      OP_AUIPC: begin
        raw_src1 = 1'b1;
        raw_src2 = 1'b1;
        raw_imm  = imm_u;
      end
      OP_LOAD, OP_JALR: begin
        raw_src2 = 1'b1;
        raw_imm  = imm_i;
      end
      OP_STORE: begin
        raw_src2 = 1'b1;
        raw_imm  = imm_s;
      end
      OP_JAL: begin
        raw_src1 = 1'b1;
        raw_src2 = 1'b1;
        raw_imm  = imm_j;
      end
      OP_BRANCH: begin
        raw_imm = imm_b;
        case (funct3)
          3'b000, 3'b001: raw_ctrl = ALU_SUB;
          3'b100, 3'b101: raw_ctrl = ALU_SLT;
          3'b110, 3'b111: raw_ctrl = ALU_SLTU;
          default:        dec_ill  = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
  end

  // An illegal entry is still issued, but with all decoded fields forced to zero.
  logic [3:0]  alu_control_d;
  logic        src1_sel_d;
  logic        src2_sel_d;
  logic [31:0] imm_d;

  assign alu_control_d = dec_ill ? ALU_ADD       : raw_ctrl;
  assign src1_sel_d    = dec_ill ? 1'b0          : raw_src1;
  assign src2_sel_d    = dec_ill ? 1'b0          : raw_src2;
  assign imm_d         = dec_ill ? 32'h0000_0000 : raw_imm;

  logic        out_valid_q;
  logic [3:0]  alu_control_q;
  logic        src1_sel_q;
  logic        src2_sel_q;
  logic [31:0] imm_q;
  logic        illegal_q;
  logic        capture;

  assign in_ready = !out_valid_q || out_ready;
  assign capture  = in_valid && in_ready;

  // Pipeline register: flush wins over capture, capture replaces, consume empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      alu_control_q <= 4'b0000;
      src1_sel_q    <= 1'b0;
      src2_sel_q    <= 1'b0;
      imm_q         <= 32'h0000_0000;
      illegal_q     <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (capture) begin
      out_valid_q   <= 1'b1;
      alu_control_q <= alu_control_d;
      src1_sel_q    <= src1_sel_d;
      src2_sel_q    <= src2_sel_d;
      imm_q         <= imm_d;
      illegal_q     <= dec_ill;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_q;
    end
  end

  assign out_valid   = out_valid_q;
  assign alu_control = alu_control_q;
  assign src1_sel    = src1_sel_q;
  assign src2_sel    = src2_sel_q;
  assign imm         = imm_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Self-checking bench for alu_decode_stage: directed scenarios plus a
// randomized run against a behavioural decode/handshake model.
module tb_alu_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_control;
  logic        src1_sel;
  logic        src2_sel;
  logic [31:0] imm;
  logic        illegal;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic        ill;
    logic [3:0]  ctrl;
    logic        s1;
    logic        s2;
    logic [31:0] imm;
  } dec_t;

  localparam logic [3:0] K_ADD = 4'd0,  K_SUB = 4'd1,  K_SLL = 4'd3,  K_SLT = 4'd4;
  localparam logic [3:0] K_XOR = 4'd5,  K_SLTU = 4'd6, K_SRL = 4'd7,  K_SRA = 4'd8;
  localparam logic [3:0] K_OR  = 4'd9,  K_AND = 4'd11, K_PASS = 4'd15;

  // model state: is an entry held, and what it decoded to
  logic m_valid;
  dec_t m_dec;

  alu_decode_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .out_valid(out_valid), .out_ready(out_ready), .alu_control(alu_control),
    .src1_sel(src1_sel), .src2_sel(src2_sel), .imm(imm), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Reference decode written from the ISA rules, immediates built arithmetically.
  function automatic dec_t ref_decode(input logic [31:0] w);
    dec_t d;
    logic [3:0] base [8];
    logic signed [31:0] sw;
    logic [31:0] sign, i_imm, s_imm, b_imm, u_imm, j_imm;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic ok;
    base  = '{K_ADD, K_SLL, K_SLT, K_SLTU, K_XOR, K_SRL, K_OR, K_AND};
    sw    = $signed(w);
    sign  = 32'(sw >>> 31);
    i_imm = 32'(sw >>> 20);
    s_imm = (i_imm & 32'hFFFF_FFE0) | {27'd0, w[11:7]};
    b_imm = (sign << 12) | ({31'd0, w[7]} << 11) | (((w >> 25) & 32'h3F) << 5) | (((w >> 8) & 32'hF) << 1);
    u_imm = w & 32'hFFFF_F000;
    j_imm = (sign << 20) | (w & 32'h000F_F000) | ({31'd0, w[20]} << 11) | (((w >> 21) & 32'h3FF) << 1);
    op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    d = '0; ok = 1'b1;
    if (op == 7'h33) begin
      if (f7 == 7'h00) d.ctrl = base[f3];
      else if (f7 == 7'h20 && f3 == 3'd0) d.ctrl = K_SUB;
      else if (f7 == 7'h20 && f3 == 3'd5) d.ctrl = K_SRA;
      else ok = 1'b0;
    end else if (op == 7'h13) begin
      d.s2 = 1'b1; d.imm = i_imm;
      if (f3 == 3'd1) begin d.ctrl = K_SLL; ok = (f7 == 7'h00); end
      else if (f3 == 3'd5) begin
        if (f7 == 7'h00) d.ctrl = K_SRL;
        else if (f7 == 7'h20) d.ctrl = K_SRA;
        else ok = 1'b0;
      end else d.ctrl = base[f3];
    end else if (op == 7'h37) begin d.ctrl = K_PASS; d.s2 = 1'b1; d.imm = u_imm; end
    else if (op == 7'h17) begin d.s1 = 1'b1; d.s2 = 1'b1; d.imm = u_imm; end
    else if (op == 7'h03 || op == 7'h67) begin d.s2 = 1'b1; d.imm = i_imm; end
    else if (op == 7'h23) begin d.s2 = 1'b1; d.imm = s_imm; end
    else if (op == 7'h6F) begin d.s1 = 1'b1; d.s2 = 1'b1; d.imm = j_imm; end
    else if (op == 7'h63) begin
      d.imm = b_imm;
      if (f3 == 3'd2 || f3 == 3'd3) ok = 1'b0;
      else d.ctrl = (f3 < 3'd4) ? K_SUB : ((f3 < 3'd6) ? K_SLT : K_SLTU);
    end else ok = 1'b0;
    if (!ok) begin d = '0; d.ill = 1'b1; end
    return d;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [9];
    logic [31:0] w;
    int sel, f;
    ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h67, 7'h6F, 7'h63};
    w   = $urandom;
    sel = $urandom_range(0, 10);
    if (sel < 9) w[6:0] = ops[sel];
    f = $urandom_range(0, 3);
    if (f == 0) w[31:25] = 7'h00;
    else if (f == 1) w[31:25] = 7'h20;
    return w;
  endfunction

  // Advance one clock: update the model from the inputs seen at the edge, settle 1 time unit after.
  task automatic tick();
    logic fire;
    logic nv;
    dec_t nd;
    fire = in_valid && (!m_valid || out_ready);
    nv = m_valid; nd = m_dec;
    if (flush) nv = 1'b0;
    else if (fire) begin nv = 1'b1; nd = ref_decode(instr); end
    else if (out_ready) nv = 1'b0;
    @(posedge clk); #1;
    m_valid = nv; m_dec = nd;
  endtask

  task automatic test_reset();
    #3;
    n_vec++;
    if ({out_valid, illegal, alu_control, src1_sel, src2_sel, imm} !== 39'd0) begin
      n_err++; $display("FAIL reset_outputs got=%h want=0", {out_valid, illegal, alu_control, src1_sel, src2_sel, imm});
    end
    in_valid = 1'b1; instr = 32'h123450B7; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({out_valid, illegal, alu_control, src1_sel, src2_sel, imm} !== 39'd0) begin
      n_err++; $display("FAIL reset_held_over_clk got=%h want=0", {out_valid, illegal, alu_control, src1_sel, src2_sel, imm});
    end
    in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    tick();
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL post_reset_idle got=%b want=0", out_valid); end
  endtask

  task automatic test_add();
    instr = 32'h002081B3; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL add_in_ready got=%b want=1", in_ready); end
    tick(); in_valid = 1'b0;
    n_vec++;
    if ({out_valid, alu_control, src2_sel, illegal} !== {1'b1, 4'b0000, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL add_decode got=%b_%b_%b_%b want=1_0000_0_0", out_valid, alu_control, src2_sel, illegal);
    end
    tick();
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL consume_clears got=%b want=0", out_valid); end
  endtask

  task automatic test_srai_lui();
    instr = 32'h40335293; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    n_vec++;
    if ({out_valid, illegal, alu_control, src2_sel, imm} !== {1'b1, 1'b0, 4'b1000, 1'b1, 32'h00000403}) begin
      n_err++; $display("FAIL srai got ctrl=%b s2=%b imm=%h ill=%b want ctrl=1000 s2=1 imm=00000403 ill=0", alu_control, src2_sel, imm, illegal);
    end
    instr = 32'h123450B7;
    tick(); in_valid = 1'b0;
    n_vec++;
    if ({out_valid, illegal, alu_control, src2_sel, imm} !== {1'b1, 1'b0, 4'b1111, 1'b1, 32'h12345000}) begin
      n_err++; $display("FAIL lui got ctrl=%b s2=%b imm=%h want ctrl=1111 s2=1 imm=12345000", alu_control, src2_sel, imm);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    instr = 32'h002081B3; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    instr = 32'h123450B7;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_vec++;
      if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready cyc=%0d got=%b want=0", k, in_ready); end
      tick();
      n_vec++;
      if ({out_valid, alu_control, imm} !== {1'b1, 4'b0000, 32'h0}) begin
        n_err++; $display("FAIL stall_hold cyc=%0d got v=%b ctrl=%b imm=%h want v=1 ctrl=0000 imm=0", k, out_valid, alu_control, imm);
      end
    end
    out_ready = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL release_in_ready got=%b want=1", in_ready); end
    tick(); in_valid = 1'b0;
    n_vec++;
    if ({out_valid, alu_control, imm} !== {1'b1, 4'b1111, 32'h12345000}) begin
      n_err++; $display("FAIL no_bubble got v=%b ctrl=%b imm=%h want v=1 ctrl=1111 imm=12345000", out_valid, alu_control, imm);
    end
    tick();
  endtask

  task automatic test_flush_illegal();
    instr = 32'h40335293; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    instr = 32'h123450B7; out_ready = 1'b1; flush = 1'b1;
    tick(); flush = 1'b0; in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_over_capture got=%b want=0", out_valid); end
    instr = 32'h00000000; in_valid = 1'b1;
    tick(); in_valid = 1'b0; out_ready = 1'b0;
    n_vec++;
    if ({out_valid, illegal, alu_control, src1_sel, src2_sel, imm} !== {1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 32'h0}) begin
      n_err++; $display("FAIL illegal_zero got v=%b ill=%b ctrl=%b s1=%b s2=%b imm=%h want v=1 ill=1 rest 0", out_valid, illegal, alu_control, src1_sel, src2_sel, imm);
    end
    flush = 1'b1;
    tick(); flush = 1'b0; out_ready = 1'b1;
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_held got=%b want=0", out_valid); end
  endtask

  task automatic test_branch();
    instr = 32'h0020E063; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    n_vec++;
    if ({illegal, alu_control, src2_sel, imm} !== {1'b0, 4'b0110, 1'b0, 32'h0}) begin
      n_err++; $display("FAIL bltu got ill=%b ctrl=%b s2=%b imm=%h want ill=0 ctrl=0110 s2=0 imm=0", illegal, alu_control, src2_sel, imm);
    end
    instr = 32'h0020A063;
    tick(); in_valid = 1'b0;
    n_vec++;
    if ({out_valid, illegal, alu_control} !== {1'b1, 1'b1, 4'b0000}) begin
      n_err++; $display("FAIL branch_f3_010 got v=%b ill=%b ctrl=%b want v=1 ill=1 ctrl=0000", out_valid, illegal, alu_control);
    end
    tick();
  endtask

  task automatic test_reset_midstream();
    instr = 32'h40335293; in_valid = 1'b1; out_ready = 1'b0;
    tick(); in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({out_valid, illegal, alu_control, src1_sel, src2_sel, imm} !== 39'd0) begin
      n_err++; $display("FAIL async_reset got=%h want=0", {out_valid, illegal, alu_control, src1_sel, src2_sel, imm});
    end
    @(negedge clk); rst_n = 1'b1;
    m_valid = 1'b0; m_dec = '0;
    instr = 32'h123450B7; in_valid = 1'b1; out_ready = 1'b1;
    tick(); in_valid = 1'b0;
    n_vec++;
    if ({out_valid, alu_control, imm} !== {1'b1, 4'b1111, 32'h12345000}) begin
      n_err++; $display("FAIL first_after_reset got v=%b ctrl=%b imm=%h want v=1 ctrl=1111 imm=12345000", out_valid, alu_control, imm);
    end
    tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      instr     = rand_instr();
      #1;
      n_vec++;
      if (in_ready !== (!m_valid || out_ready)) begin
        n_err++; $display("FAIL rnd_in_ready cyc=%0d got=%b want=%b", k, in_ready, !m_valid || out_ready);
      end
      tick();
      n_vec++;
      if (out_valid !== m_valid) begin
        n_err++; $display("FAIL rnd_out_valid cyc=%0d got=%b want=%b", k, out_valid, m_valid);
      end
      if (m_valid) begin
        n_vec++;
        if ({illegal, alu_control, src1_sel, src2_sel, imm} !== m_dec) begin
          n_err++; $display("FAIL rnd_fields cyc=%0d got=%h want=%h", k, {illegal, alu_control, src1_sel, src2_sel, imm}, m_dec);
        end
      end
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = 32'h0;
    m_valid = 1'b0; m_dec = '0;
    test_reset();
    test_add();
    test_srai_lui();
    test_back_to_back();
    test_flush_illegal();
    test_branch();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
